// File: rtl/ultrasonic_capture_scheduler.sv
// rtl/ultrasonic_capture_scheduler.sv - per-channel clear/settle/capture/drain sequencer for one ultrasonic receiver
//
// Purpose:
//   Steps a single receiver (ADC sampler + sample FIFO) across up to four ADC
//   channels. For every enabled channel, in ascending order, it flushes the
//   receiver, waits for the front end to settle, samples for a fixed window and
//   then streams the FIFO contents to the host through a one-entry output register.
//
// Ports:
//   SYS_CLK, RST       clock, synchronous active-high reset
//   start_i            1-cycle pulse, begins a scan of ch_mask_i (ignored when busy or mask==0)
//   ch_mask_i[3:0]     channel enable mask, latched on an accepted start
//   busy_o             high in every state except IDLE
//   done_o             1-cycle pulse at scan end
//   overflow_o         sticky: receiver FIFO filled during a window of the current scan
//   rx_rst_o           receiver clear (one cycle per channel)
//   rx_on_o            receiver sampling enable (capture window only)
//   rx_ch_sel_o[1:0]   receiver channel select
//   rx_read_req_o      receiver FIFO read request
//   rx_empty_i         receiver FIFO empty
//   rx_full_i          receiver FIFO full
//   rx_data_i[15:0]    receiver FIFO data, valid the cycle after a read request
//   dout_o[15:0]       sample word to host
//   dout_ch_o[1:0]     channel of dout_o
//   dout_last_o        final word of this channel
//   dout_valid_o       dout_* valid
//   dout_ready_i       host accepts the word when dout_valid_o & dout_ready_i

module ultrasonic_capture_scheduler #(
  parameter int WIN_BITS      = 24,
  parameter int WIN_CYCLES    = 200000,
  parameter int SETTLE_CYCLES = 16,
  parameter int GAP_CYCLES    = 4
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic        start_i,
  input  logic [3:0]  ch_mask_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o,
  output logic        rx_rst_o,
  output logic        rx_on_o,
  output logic [1:0]  rx_ch_sel_o,
  output logic        rx_read_req_o,
  input  logic        rx_empty_i,
  input  logic        rx_full_i,
  input  logic [15:0] rx_data_i,
  output logic [15:0] dout_o,
  output logic [1:0]  dout_ch_o,
  output logic        dout_last_o,
  output logic        dout_valid_o,
  input  logic        dout_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SETTLE,
    S_CAPTURE,
    S_GAP,
    S_DRAIN,
    S_NEXT,
    S_FINISH
  } state_t;

  // Counters load "length - 1" on state entry and leave the state when they reach zero.
  localparam logic [WIN_BITS-1:0] WIN_LOAD    = WIN_BITS'(WIN_CYCLES - 1);
  localparam logic [WIN_BITS-1:0] SETTLE_LOAD = WIN_BITS'(SETTLE_CYCLES - 1);
  localparam logic [WIN_BITS-1:0] GAP_LOAD    = WIN_BITS'(GAP_CYCLES - 1);

  state_t              state_q, state_d;
  logic [WIN_BITS-1:0] cnt_q, cnt_d;
  logic [3:0]          mask_q;
  logic [1:0]          ch_q;
  logic                ovf_q;
  logic                busy_q, done_q, rx_rst_q, rx_on_q;
  logic                rd_pend_q;
  logic [15:0]         dout_q;
  logic [1:0]          dout_ch_q;
  logic                dout_last_q, dout_valid_q;

  logic                cnt_zero;
  logic [3:0]          above_mask;
  logic                has_next;
  logic                rd_req;
  logic                drain_done;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] r;
    casez (m)
      4'b???1: r = 2'd0;
      4'b??10: r = 2'd1;
      4'b?100: r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  assign cnt_zero   = (cnt_q == '0);
  // Enabled channels strictly above the current one.
  assign above_mask = mask_q & (4'b1110 << ch_q);
  assign has_next   = |above_mask;

  // A read is only issued when its data is guaranteed a free output register on
  // arrival: the register is empty now, or its word is being taken this cycle.
  // The pending flag keeps at most one read in flight.
  assign rd_req     = (state_q == S_DRAIN) && !rx_empty_i && !rd_pend_q &&
                      (!dout_valid_q || dout_ready_i);
  assign drain_done = rx_empty_i && !rd_pend_q && !dout_valid_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i && (ch_mask_i != 4'd0)) state_d = S_CLEAR;
      S_CLEAR:   state_d = S_SETTLE;
      S_SETTLE:  if (cnt_zero) state_d = S_CAPTURE;
      S_CAPTURE: if (rx_full_i || cnt_zero) state_d = S_GAP;
      S_GAP:     if (cnt_zero) state_d = S_DRAIN;
      S_DRAIN:   if (drain_done) state_d = S_NEXT;
      S_NEXT:    state_d = has_next ? S_CLEAR : S_FINISH;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        S_SETTLE:  cnt_d = SETTLE_LOAD;
        S_CAPTURE: cnt_d = WIN_LOAD;
        S_GAP:     cnt_d = GAP_LOAD;
        default:   cnt_d = '0;
      endcase
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - WIN_BITS'(1);
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mask_q       <= 4'd0;
      ch_q         <= 2'd0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rx_rst_q     <= 1'b0;
      rx_on_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      dout_q       <= 16'd0;
      dout_ch_q    <= 2'd0;
      dout_last_q  <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      // Control outputs are registered from the next state so they line up
      // exactly with the state they belong to.
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_FINISH);
      rx_rst_q <= (state_d == S_CLEAR);
      rx_on_q  <= (state_d == S_CAPTURE);

      if ((state_q == S_IDLE) && (state_d == S_CLEAR)) begin
        mask_q <= ch_mask_i;
        ch_q   <= lowest_set(ch_mask_i);
        ovf_q  <= 1'b0;
      end

      if ((state_q == S_NEXT) && has_next) begin
        ch_q <= lowest_set(above_mask);
      end

      if ((state_q == S_CAPTURE) && rx_full_i) begin
        ovf_q <= 1'b1;
      end

      rd_pend_q <= rd_req;

      // rx_empty_i in the data cycle already reflects the read just made, so
      // it tells whether this word was the last one in the FIFO.
      if (rd_pend_q) begin
        dout_q       <= rx_data_i;
        dout_ch_q    <= ch_q;
        dout_last_q  <= rx_empty_i;
        dout_valid_q <= 1'b1;
      end else if (dout_ready_i) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign overflow_o    = ovf_q;
  assign rx_rst_o      = rx_rst_q;
  assign rx_on_o       = rx_on_q;
  assign rx_ch_sel_o   = ch_q;
  assign rx_read_req_o = rd_req;
  assign dout_o        = dout_q;
  assign dout_ch_o     = dout_ch_q;
  assign dout_last_o   = dout_last_q;
  assign dout_valid_o  = dout_valid_q;

endmodule

// File: tb/tb_ultrasonic_capture_scheduler.sv
// tb/tb_ultrasonic_capture_scheduler.sv - randomized self-checking bench for ultrasonic_capture_scheduler

module tb_ultrasonic_capture_scheduler;

  localparam int WIN    = 100;
  localparam int SETTLE = 16;
  localparam int GAP    = 4;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  ch_mask = 4'd0;
  logic        busy, done, overflow, rx_rst, rx_on, rx_read_req;
  logic [1:0]  rx_ch_sel;
  logic        rx_empty = 1'b1;
  logic        rx_full = 1'b0;
  logic [15:0] rx_data = 16'd0;
  logic [15:0] dout;
  logic [1:0]  dout_ch;
  logic        dout_last, dout_valid;
  logic        dout_ready = 1'b0;

  always #5 SYS_CLK = ~SYS_CLK;

  ultrasonic_capture_scheduler #(
    .WIN_BITS(24), .WIN_CYCLES(WIN), .SETTLE_CYCLES(SETTLE), .GAP_CYCLES(GAP)
  ) dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .start_i(start), .ch_mask_i(ch_mask),
    .busy_o(busy), .done_o(done), .overflow_o(overflow),
    .rx_rst_o(rx_rst), .rx_on_o(rx_on), .rx_ch_sel_o(rx_ch_sel),
    .rx_read_req_o(rx_read_req), .rx_empty_i(rx_empty), .rx_full_i(rx_full),
    .rx_data_i(rx_data), .dout_o(dout), .dout_ch_o(dout_ch),
    .dout_last_o(dout_last), .dout_valid_o(dout_valid), .dout_ready_i(dout_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed { logic [1:0] ch; logic [15:0] data; logic last; } word_t;
  typedef struct packed { logic [1:0] ch; logic [31:0] len; } win_t;

  word_t       exp_q[$];
  win_t        win_q[$];
  logic [15:0] plan_data [4][8];
  int          plan_len [4];
  int          full_at [4];
  int          ready_pct = 100;
  bit          mon_en = 1'b0;

  // Receiver model: flushed by rx_rst, writes the planned words of the selected
  // channel every third sampling cycle, raises a sticky full at a planned cycle.
  logic [15:0] fifo[$];
  int          cap_cnt = 0;
  int          wr_idx = 0;
  logic [1:0]  cur_ch = 2'd0;
  bit          full_flag = 1'b0;

  always @(posedge SYS_CLK) begin
    if (RST || rx_rst) begin
      fifo.delete();
      cap_cnt   = 0;
      wr_idx    = 0;
      full_flag = 1'b0;
      cur_ch    = rx_ch_sel;
    end else begin
      if (rx_read_req) begin
        check("read_nonempty", fifo.size() != 0, 1);
        if (fifo.size() != 0) rx_data <= fifo.pop_front();
      end
      if (rx_on) begin
        if (!full_flag && wr_idx < plan_len[cur_ch] && cap_cnt == wr_idx * 3 + 1) begin
          fifo.push_back(plan_data[cur_ch][wr_idx]);
          wr_idx++;
        end
        cap_cnt++;
        if (full_at[cur_ch] > 0 && cap_cnt == full_at[cur_ch] - 1) full_flag = 1'b1;
      end
    end
    rx_empty   <= (fifo.size() == 0);
    rx_full    <= full_flag;
    dout_ready <= (int'($urandom_range(99)) < ready_pct);
  end

  // Protocol monitor and output scoreboard, sampled mid-cycle.
  int    cyc = 0;
  int    on_len = 0;
  logic [1:0] on_ch = 2'd0;
  int    settle_cnt = 0;
  bit    in_settle = 1'b0;
  int    off_cnt = 1000;
  bit    prev_rst = 1'b0;
  bit    prev_done = 1'b0;
  bit    prev_stall = 1'b0;
  word_t prev_word;
  int    done_cnt = 0;
  int    rst_cnt = 0;
  bit    acc_seen = 1'b0;
  logic [1:0] last_acc_ch = 2'd0;
  int    last_acc_cyc = 0;

  always @(negedge SYS_CLK) begin
    word_t w;
    win_t  ww;
    cyc++;
    if (!mon_en) begin
      on_len = 0; in_settle = 0; prev_stall = 0; off_cnt = 1000; acc_seen = 0;
    end else begin
      if (rx_rst) begin
        check("rx_rst_width", prev_rst, 0);
        rst_cnt++;
        in_settle = 1; settle_cnt = 0; acc_seen = 0;
      end else if (in_settle && !rx_on) begin
        settle_cnt++;
      end
      if (rx_on) begin
        if (in_settle) begin
          check("settle_len", settle_cnt, SETTLE);
          in_settle = 0;
        end
        on_len++; on_ch = rx_ch_sel; off_cnt = 0;
      end else begin
        off_cnt++;
        if (on_len > 0) begin
          check("window_expected", win_q.size() > 0, 1);
          if (win_q.size() > 0) begin
            ww = win_q.pop_front();
            check("window_len", on_len, ww.len);
            check("window_ch", on_ch, ww.ch);
          end
          on_len = 0;
        end
      end
      if (rx_read_req) check("read_after_gap", off_cnt > GAP, 1);
      if (prev_stall) begin
        check("stall_valid", dout_valid, 1);
        check("stall_word", {dout_ch, dout, dout_last}, prev_word);
      end
      if (dout_valid && dout_ready) begin
        check("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("dout", dout, w.data);
          check("dout_ch", dout_ch, w.ch);
          check("dout_last", dout_last, w.last);
        end
        if (ready_pct == 100 && acc_seen && last_acc_ch == dout_ch)
          check("throughput", cyc - last_acc_cyc, 2);
        acc_seen = 1; last_acc_ch = dout_ch; last_acc_cyc = cyc;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_word  = {dout_ch, dout, dout_last};
      if (done) begin
        check("done_width", prev_done, 0);
        done_cnt++;
      end
    end
    prev_rst  = rx_rst;
    prev_done = done;
  end

  task automatic set_plan(input int c, input int n, input int fa);
    plan_len[c] = n;
    full_at[c]  = fa;
    for (int k = 0; k < 8; k++) plan_data[c][k] = 16'($urandom);
  endtask

  task automatic run_scan(input logic [3:0] mask, input int poke_at);
    bit exp_ovf;
    int nch;
    bit finished;
    exp_ovf = 0;
    nch = 0;
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        nch++;
        for (int k = 0; k < plan_len[c]; k++)
          exp_q.push_back('{ch: 2'(c), data: plan_data[c][k], last: (k == plan_len[c] - 1)});
        win_q.push_back('{ch: 2'(c), len: (full_at[c] > 0) ? full_at[c] : WIN});
        if (full_at[c] > 0) exp_ovf = 1;
      end
    end
    rst_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    ch_mask = mask;
    @(negedge SYS_CLK);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    finished = 0;
    for (int i = 0; i < 4000 && !finished; i++) begin
      @(negedge SYS_CLK);
      if (i == poke_at) begin
        start = 1'b1;
        ch_mask = 4'hF;
      end else begin
        start = 1'b0;
      end
      if (done) finished = 1;
    end
    start = 1'b0;
    check("scan_finished", finished, 1);
    @(negedge SYS_CLK);
    check("busy_after_done", busy, 0);
    check("done_single_cycle", done, 0);
    repeat (3) @(negedge SYS_CLK);
    check("done_count", done_cnt, 1);
    check("rx_rst_pulses", rst_cnt, nch);
    check("overflow", overflow, exp_ovf);
    check("words_left", exp_q.size(), 0);
    check("windows_left", win_q.size(), 0);
    exp_q.delete();
    win_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit saw_done;
    logic [3:0] m;
    for (int c = 0; c < 4; c++) set_plan(c, 0, 0);

    // Reset state
    RST = 1'b1;
    repeat (3) @(negedge SYS_CLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rx_rst", rx_rst, 0);
    check("rst_rx_on", rx_on, 0);
    check("rst_rx_ch_sel", rx_ch_sel, 0);
    check("rst_read_req", rx_read_req, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    RST = 1'b0;
    mon_en = 1'b1;
    @(negedge SYS_CLK);

    // Single channel 2, five words, host always ready
    ready_pct = 100;
    set_plan(2, 5, 0);
    run_scan(4'b0100, -1);

    // Scan 0,1,3 with channel 1 producing nothing
    set_plan(0, 3, 0);
    set_plan(1, 0, 0);
    set_plan(3, 6, 0);
    run_scan(4'b1011, -1);

    // FIFO full during channel 0 at capture cycle 40
    set_plan(0, 4, 40);
    set_plan(1, 2, 0);
    run_scan(4'b0011, -1);
    repeat (10) @(negedge SYS_CLK);
    check("overflow_sticky", overflow, 1);

    // Full coinciding with the last window cycle
    set_plan(3, 3, WIN);
    run_scan(4'b1000, -1);

    // START with empty mask is ignored, overflow untouched
    start = 1'b1;
    ch_mask = 4'd0;
    @(negedge SYS_CLK);
    start = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      check("mask0_busy", busy, 0);
      check("mask0_rx_rst", rx_rst, 0);
      saw_done |= done;
      @(negedge SYS_CLK);
    end
    check("mask0_done", saw_done, 0);
    check("mask0_overflow", overflow, 1);

    // START while busy is ignored
    set_plan(1, 4, 0);
    run_scan(4'b0010, 30);

    // Random scans with host backpressure
    ready_pct = 30;
    for (int s = 0; s < 5; s++) begin
      m = 4'($urandom_range(15, 1));
      for (int c = 0; c < 4; c++) set_plan(c, $urandom_range(8), ($urandom_range(3) == 0) ? $urandom_range(60, 30) : 0);
      run_scan(m, (s == 2) ? 60 : -1);
    end

    // Reset in the middle of a capture window aborts the scan
    ready_pct = 100;
    mon_en = 1'b0;
    set_plan(0, 3, 0);
    start = 1'b1;
    ch_mask = 4'b0001;
    @(negedge SYS_CLK);
    start = 1'b0;
    for (int i = 0; i < 200 && !rx_on; i++) @(negedge SYS_CLK);
    check("abort_reached_capture", rx_on, 1);
    repeat (10) @(negedge SYS_CLK);
    RST = 1'b1;
    @(negedge SYS_CLK);
    RST = 1'b0;
    check("abort_rx_on", rx_on, 0);
    check("abort_busy", busy, 0);
    check("abort_dout_valid", dout_valid, 0);
    check("abort_rx_ch_sel", rx_ch_sel, 0);
    saw_done = 0;
    for (int i = 0; i < 200; i++) begin
      saw_done |= done;
      @(negedge SYS_CLK);
    end
    check("abort_no_done", saw_done, 0);
    check("abort_idle", busy, 0);

    // Recovery after abort
    mon_en = 1'b1;
    @(negedge SYS_CLK);
    set_plan(1, 5, 0);
    run_scan(4'b0010, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
